fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Instruction-fetch front end of the 5-stage LEGv8 pipeline. Replaces the bare PC register ahead of the IF_ID register.
- Holds the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Buffers returned {PC, instruction} pairs in a small FIFO and presents the head to IF_ID with a valid/stall handshake.
- Handles the branch redirect (PCSrc_F / PCBranch_F) produced by the MEM stage, including flush of buffered and in-flight fetches.

Parameters:
N, 64, address/PC width
DEPTH, 4, FIFO entries (power of 2, >= 2)
NOP, 32'hD503201F, instruction driven when the FIFO is empty

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
PCSrc_F  in  1  branch taken (redirect/flush) from MEM stage
PCBranch_F  in  N  redirect target, valid when PCSrc_F=1
stall_F  in  1  downstream hold; head is not consumed while high
imem_req  out  1  fetch request to instruction memory
imem_addr_F  out  N  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  memory completes the current request this cycle
imem_rdata  in  32  instruction word, valid when imem_req & imem_ready
inst_valid_F  out  1  FIFO head valid
inst_pc_F  out  N  PC of head entry (0 when empty)
inst_F  out  32  head instruction (NOP when empty)

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_next=0, count=0, read/write pointers=0, state=IDLE.
  - Outputs: imem_req=0, imem_addr_F=0, inst_valid_F=0, inst_pc_F=0, inst_F=NOP.
  - Reset asserted mid-request abandons the request. Memory must tolerate req dropping.
- Registers: pc_next (next address to fetch), req_addr (address of the in-flight request), FIFO of DEPTH x (N+32), count 0..DEPTH.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if !PCSrc_F && count<DEPTH, then req_addr<=pc_next, pc_next<=pc_next+4, go to WAIT. imem_req=0 in IDLE.
  - WAIT: imem_req=1, imem_addr_F=req_addr.
    - On imem_ready && !PCSrc_F: push {req_addr, imem_rdata}, go to IDLE.
    - On PCSrc_F && !imem_ready: go to DISCARD (request cannot be withdrawn).
    - On PCSrc_F && imem_ready: drop data, go to IDLE.
  - DISCARD: imem_req=1, address unchanged. On imem_ready, drop data and go to IDLE. A further PCSrc_F in DISCARD only updates pc_next.
- Issue gating: count<DEPTH is checked at issue. Count cannot rise while a request is in flight, so push never overflows.
- Throughput:
  - Requests issue every other cycle at best (IDLE→WAIT→IDLE).
  - Latency from imem_ready to inst_valid_F is 1 cycle. There is no bypass.
- Pop: when inst_valid_F && !stall_F && !PCSrc_F, the read pointer advances at the clock edge. Push and pop in the same cycle leave count unchanged.
- Redirect (PCSrc_F=1):
  - pc_next<=PCBranch_F; FIFO cleared (count=0, pointers equal); pop suppressed.
  - Takes priority over stall_F, push, and issue.
  - The first request to the target is issued from IDLE in the cycle after the redirect, or after DISCARD completes.
- PC arithmetic: modulo 2^N; wrap from 2^N-4 to 0 is silent. PCBranch_F is used as given (no alignment check).
- Outputs inst_pc_F / inst_F are combinational from the FIFO head. When count=0 they show 0 / NOP.

Test Plan:
- Reset release, imem_ready tied 1, stall_F=0:
  - imem_addr_F sequence 0,4,8 on every second cycle.
  - inst_valid_F first high 1 cycle after the first ready, showing inst_pc_F=0.
- Stall fill: stall_F=1, ready=1 → count reaches 4 after PCs 0..12 are buffered. imem_req stays 0 while full. Release stall → head pops 0,4,8,12 on consecutive cycles, and fetch resumes at 16.
- Redirect, no in-flight request: 3 entries buffered, PCSrc_F=1, PCBranch_F=0x100 → next cycle inst_valid_F=0, inst_F=NOP, and the next imem_addr_F=0x100.
- Redirect during WAIT: ready delayed 3 cycles with req_addr=0x20, PCSrc_F pulses to target 0x200 → 0x20 data is never presented, and the next request address is 0x200.
- Simultaneous redirect and ready: PCSrc_F=1 on the same cycle as imem_ready → returned word dropped, count=0, and the next request goes to the target. Also check that stall_F=1 on the same cycle does not keep any entry.
- Async reset mid-WAIT: drive reset=0 between edges → imem_req=0 and inst_valid_F=0 immediately. After release, fetch restarts at 0.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: MEM-stage redirect, IF_ID handshake and instruction memory port.
// Pure wiring, no latency.
// Backpressure travels on stall_F (downstream) and imem_ready (memory side).
interface fetch_queue_unit_if #(
  parameter int N = 64
);
  logic          PCSrc_F;
  logic [N-1:0]  PCBranch_F;
  logic          stall_F;
  logic          imem_req;
  logic [N-1:0]  imem_addr_F;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic          inst_valid_F;
  logic [N-1:0]  inst_pc_F;
  logic [31:0]   inst_F;

  // The fetch unit drives the memory request and the IF_ID-facing head.
  modport master (
    input  PCSrc_F, PCBranch_F, stall_F, imem_ready, imem_rdata,
    output imem_req, imem_addr_F, inst_valid_F, inst_pc_F, inst_F
  );

  // Pipeline / memory side of the same bus.
  modport slave (
    output PCSrc_F, PCBranch_F, stall_F, imem_ready, imem_rdata,
    input  imem_req, imem_addr_F, inst_valid_F, inst_pc_F, inst_F
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// LEGv8 fetch front end: PC, single outstanding imem request, {PC,inst} FIFO feeding IF_ID.
// Latency: imem_ready to inst_valid_F is one cycle; issue at best every other cycle.
// Backpressure: stall_F holds the head; issue stops while the FIFO is full; redirect flushes.
module fetch_queue_unit #(
  parameter int          N     = 64,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'hD503201F
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_unit_if.master fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pc_q, pc_d;
  logic [N-1:0]    req_addr_q, req_addr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            issue;
  logic            head_vld;

  // Request FSM: issue from IDLE, wait for memory, swallow a response made stale by a redirect.
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    push           = 1'b0;
    issue          = 1'b0;
    fq.imem_req    = 1'b0;
    fq.imem_addr_F = '0;
    case (state_q)
      IDLE: begin
        if (!fq.PCSrc_F && (count_q < FULL)) begin
          issue      = 1'b1;
          req_addr_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        fq.imem_req    = 1'b1;
        fq.imem_addr_F = req_addr_q;
        if (fq.imem_ready) begin
          // A redirect in the same cycle makes the returned word stale.
          push    = !fq.PCSrc_F;
          state_d = IDLE;
        end else if (fq.PCSrc_F) begin
          // The memory cannot be told to abandon the access; wait it out.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        fq.imem_req    = 1'b1;
        fq.imem_addr_F = req_addr_q;
        if (fq.imem_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next fetch PC: redirect wins, otherwise advance by one word on each issue (wraps silently).
  always_comb begin
    pc_d = pc_q;
    if (fq.PCSrc_F) begin
      pc_d = fq.PCBranch_F;
    end else if (issue) begin
      pc_d = pc_q + N'(4);
    end
  end

  // FIFO bookkeeping: redirect empties it outright, otherwise push/pop adjust pointers and count.
  always_comb begin
    head_vld = (count_q != '0);
    pop      = head_vld && !fq.stall_F && !fq.PCSrc_F;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fq.PCSrc_F) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only observed through count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_addr_q;
      inst_mem_q[wr_ptr_q] <= fq.imem_rdata;
    end
  end

  // Head presentation to IF_ID: zero PC and NOP whenever the FIFO is empty.
  always_comb begin
    fq.inst_valid_F = head_vld;
    fq.inst_pc_F    = head_vld ? pc_mem_q[rd_ptr_q] : '0;
    fq.inst_F       = head_vld ? inst_mem_q[rd_ptr_q] : NOP;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed table, multi-cycle corner sequences, random traffic.
// Outputs compared every cycle one time unit after the rising edge.
// Memory returns a fixed hash of the request address so data is traceable.
module tb_fetch_queue_unit;

  localparam int          N     = 64;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hD503201F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.N(N)) bus ();

  fetch_queue_unit #(.N(N), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (bus)
  );

  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A3C_0F96;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr_F);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: a queue plus an outstanding-request record ----------------
  typedef struct packed {
    logic [N-1:0] pc;
    logic [31:0]  inst;
  } ent_t;

  ent_t         m_q[$];
  logic [N-1:0] m_pc;
  logic [N-1:0] m_addr;
  bit           m_busy;
  bit           m_doomed;

  task automatic model_reset();
    m_q.delete();
    m_pc     = '0;
    m_addr   = '0;
    m_busy   = 1'b0;
    m_doomed = 1'b0;
  endtask

  task automatic model_step(input bit stall, input bit br, input logic [N-1:0] tgt, input bit rdy);
    bit was_full;
    was_full = (m_q.size() >= DEPTH);
    if (br) begin
      m_q.delete();
      m_pc = tgt;
      if (m_busy) begin
        if (rdy) begin
          m_busy   = 1'b0;
          m_doomed = 1'b0;
        end else begin
          m_doomed = 1'b1;
        end
      end
    end else begin
      if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
      if (m_busy) begin
        if (rdy) begin
          if (!m_doomed) m_q.push_back('{pc: m_addr, inst: mem_word(m_addr)});
          m_busy   = 1'b0;
          m_doomed = 1'b0;
        end
      end else if (!was_full) begin
        m_busy   = 1'b1;
        m_doomed = 1'b0;
        m_addr   = m_pc;
        m_pc     = m_pc + 64'd4;
      end
    end
  endtask

  task automatic check_model();
    chk("m_req", 64'(bus.imem_req), 64'(m_busy));
    if (m_busy) chk("m_addr", 64'(bus.imem_addr_F), 64'(m_addr));
    chk("m_vld", 64'(bus.inst_valid_F), 64'(m_q.size() > 0));
    chk("m_pc", 64'(bus.inst_pc_F), (m_q.size() > 0) ? 64'(m_q[0].pc) : 64'd0);
    chk("m_inst", 64'(bus.inst_F), (m_q.size() > 0) ? 64'(m_q[0].inst) : 64'(NOP));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input bit stall, input bit br, input logic [N-1:0] tgt, input bit rdy);
    bus.stall_F    = stall;
    bus.PCSrc_F    = br;
    bus.PCBranch_F = tgt;
    bus.imem_ready = rdy;
    model_step(stall, br, tgt, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.stall_F    = 1'b0;
    bus.PCSrc_F    = 1'b0;
    bus.PCBranch_F = '0;
    bus.imem_ready = 1'b0;
    #2;
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr_F), 64'd0);
    chk("rst_vld", 64'(bus.inst_valid_F), 64'd0);
    chk("rst_pc", 64'(bus.inst_pc_F), 64'd0);
    chk("rst_inst", 64'(bus.inst_F), 64'(NOP));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit           stall;
    bit           rdy;
    bit           br;
    logic [N-1:0] tgt;
    bit           e_req;
    logic [N-1:0] e_addr;
    bit           e_vld;
    logic [N-1:0] e_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Free-running fetch after reset, ready tied high, no stall.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h4, 1'b0, 64'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h4};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8, 1'b0, 64'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h8};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'hC, 1'b0, 64'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'hC};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
      chk("tbl_req", 64'(bus.imem_req), 64'(tbl[i].e_req));
      if (tbl[i].e_req) chk("tbl_addr", 64'(bus.imem_addr_F), 64'(tbl[i].e_addr));
      chk("tbl_vld", 64'(bus.inst_valid_F), 64'(tbl[i].e_vld));
      chk("tbl_pc", 64'(bus.inst_pc_F), 64'(tbl[i].e_pc));
      chk("tbl_inst", 64'(bus.inst_F), tbl[i].e_vld ? 64'(mem_word(tbl[i].e_pc)) : 64'(NOP));
    end

    // Stall fill to full, then drain in order and resume at 16.
    do_reset();
    repeat (10) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("full_req", 64'(bus.imem_req), 64'd0);
    chk("full_vld", 64'(bus.inst_valid_F), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("pop_order", 64'(bus.inst_pc_F), 64'(4 * k));
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    chk("resume_pc", 64'(bus.inst_pc_F), 64'h10);

    // Redirect with three entries buffered and nothing in flight.
    do_reset();
    repeat (6) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("pre_redir_vld", 64'(bus.inst_valid_F), 64'd1);
    cyc(1'b1, 1'b1, 64'h100, 1'b1);
    chk("redir_vld", 64'(bus.inst_valid_F), 64'd0);
    chk("redir_inst", 64'(bus.inst_F), 64'(NOP));
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("redir_req", 64'(bus.imem_req), 64'd1);
    chk("redir_addr", 64'(bus.imem_addr_F), 64'h100);

    // Redirect while a slow request to 0x20 is outstanding.
    do_reset();
    cyc(1'b0, 1'b1, 64'h20, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("wait_addr", 64'(bus.imem_addr_F), 64'h20);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 64'h200, 1'b0);
    chk("disc_req", 64'(bus.imem_req), 64'd1);
    chk("disc_addr", 64'(bus.imem_addr_F), 64'h20);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("disc_drop_vld", 64'(bus.inst_valid_F), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("disc_next_addr", 64'(bus.imem_addr_F), 64'h200);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("disc_head_pc", 64'(bus.inst_pc_F), 64'h200);

    // Redirect coinciding with ready and stall.
    do_reset();
    repeat (4) cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 64'h300, 1'b1);
    chk("sim_vld", 64'(bus.inst_valid_F), 64'd0);
    chk("sim_req", 64'(bus.imem_req), 64'd0);
    chk("sim_inst", 64'(bus.inst_F), 64'(NOP));
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("sim_next_addr", 64'(bus.imem_addr_F), 64'h300);

    // Asynchronous reset between edges while a request is waiting.
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'd0);
    chk("arst_vld", 64'(bus.inst_valid_F), 64'd0);
    chk("arst_inst", 64'(bus.inst_F), 64'(NOP));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("arst_restart", 64'(bus.imem_addr_F), 64'h0);

    // Random traffic against the model, including redirects near the top of the address space.
    do_reset();
    begin
      int stall_pct;
      stall_pct = 20;
      for (int c = 0; c < 3000; c++) begin
        bit           s, b, r;
        logic [N-1:0] t;
        if (c % 200 == 0) stall_pct = $urandom_range(0, 90);
        s = ($urandom_range(0, 99) < stall_pct);
        b = ($urandom_range(0, 19) == 0);
        r = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 3))
          0:       t = {$urandom, $urandom};
          1:       t = 64'hFFFF_FFFF_FFFF_FFF4;
          default: t = {54'd0, 10'($urandom_range(0, 255) << 2)};
        endcase
        cyc(s, b, t, r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
